// File: rtl/prescaled_mod_cnt_pkg.sv
// Shared constants for the prescaled modulo counter.
// Direction encodings and default parameter values.
package prescaled_mod_cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_MOD   = 60;
    localparam int DEF_DIV_W = 32;

endpackage

// File: rtl/prescaled_mod_cnt_tick_gen.sv
// Prescaler: divides clk by num and flags the step edge.
// num of 0 or 1 means every enabled edge is a step edge.
module tick_gen
    import prescaled_mod_cnt_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] num,
    input  logic             en,
    input  logic             restart,
    output logic             tick_pre
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] lim;
    logic             wrap;

    // ">=" so that lowering num mid-period steps on the next edge
    assign lim      = (num == '0) ? '0 : num - DIV_W'(1);
    assign wrap     = (div_cnt >= lim);
    assign tick_pre = en & ~restart & wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (restart) begin
            div_cnt <= '0;
        end else if (en) begin
            if (wrap) div_cnt <= '0;
            else      div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/prescaled_mod_cnt.sv
// Modulo-MOD up/down counter advanced by a programmable prescaler.
// Priority clr > load > step; out, tick and carry are all registered.
module prescaled_mod_cnt
    import prescaled_mod_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] num,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             carry
);

    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

    logic             step;
    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] next_up;
    logic [WIDTH-1:0] next_dn;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .num      (num),
        .en       (en),
        .restart  (clr | load),
        .tick_pre (step)
    );

    // Compare in WIDTH+1 bits so MOD == 2^WIDTH never overflows
    assign clamped = ({1'b0, load_val} >= MOD_X) ? TOP : load_val;
    assign next_up = (out == TOP) ? '0 : out + WIDTH'(1);
    assign next_dn = (out == '0) ? TOP : out - WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            tick  <= 1'b0;
            carry <= 1'b0;
        end else begin
            tick  <= 1'b0;
            carry <= 1'b0;
            if (clr) begin
                out <= '0;
            end else if (load) begin
                out <= clamped;
            end else if (step) begin
                tick <= 1'b1;
                if (up == CNT_UP) begin
                    out   <= next_up;
                    carry <= (out == TOP);
                end else begin
                    out   <= next_dn;
                    carry <= (out == '0);
                end
            end
        end
    end

endmodule
